// File: rtl/affine_seq.sv
// Sequences the register file through one affine transform per job: accept x1/y1, read back, write x2/y2.
// out_valid rises 3 edges after y1 is accepted; in_ready is low from FETCH to DONE, and DONE holds until out_ready.
module affine_seq #(
  parameter int n   = 8,
  parameter int A11 = 96,
  parameter int A12 = 64,
  parameter int A21 = -64,
  parameter int A22 = 96,
  parameter int B1  = 20,
  parameter int B2  = -20
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic signed [n-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                write,
  output logic        [1:0]   Raddr1,
  output logic        [1:0]   Raddr2,
  output logic        [n-1:0] Wdata,
  input  logic signed [n-1:0] Rdata1,
  input  logic signed [n-1:0] Rdata2
);

  localparam int FRAC = 7;

  localparam logic signed [n-1:0] a11_c = n'(A11);
  localparam logic signed [n-1:0] a12_c = n'(A12);
  localparam logic signed [n-1:0] a21_c = n'(A21);
  localparam logic signed [n-1:0] a22_c = n'(A22);
  localparam logic signed [n-1:0] b1_c  = n'(B1);
  localparam logic signed [n-1:0] b2_c  = n'(B2);

  typedef enum logic [2:0] {
    IDLE,
    GET_Y,
    FETCH,
    WR_X2,
    WR_Y2,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic signed [n-1:0] x_q, y_q;
  logic signed [n-1:0] x2, y2;

  // Full-width product, floor shift back to Q0, keep the low n bits.
  function automatic logic signed [n-1:0] term(input logic signed [n-1:0] a,
                                               input logic signed [n-1:0] b);
    logic signed [2*n-1:0] p;
    p = a * b;
    return n'(p >>> FRAC);
  endfunction

  assign x2 = term(x_q, a11_c) + term(y_q, a12_c) + b1_c;
  assign y2 = term(x_q, a21_c) + term(y_q, a22_c) + b2_c;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) begin
        x_q <= Rdata1;
        y_q <= Rdata2;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    write     = 1'b0;
    Raddr1    = 2'd0;
    Raddr2    = 2'd1;
    Wdata     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          write     = 1'b1;
          Wdata     = in_data;
          state_nxt = GET_Y;
        end
      end
      GET_Y: begin
        in_ready = 1'b1;
        if (in_valid) begin
          write     = 1'b1;
          Raddr1    = 2'd1;
          Wdata     = in_data;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = WR_X2;
      WR_X2: begin
        write     = 1'b1;
        Raddr1    = 2'd2;
        Wdata     = x2;
        state_nxt = WR_Y2;
      end
      WR_Y2: begin
        write     = 1'b1;
        Raddr1    = 2'd3;
        Wdata     = y2;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_affine_seq.sv
// Directed bench for affine_seq with a behavioural 4-entry register file.
`timescale 1ns/1ps
module tb_affine_seq;

  logic              clk = 1'b0;
  logic              n_reset = 1'b0;
  logic signed [7:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              write;
  logic        [1:0] Raddr1, Raddr2;
  logic        [7:0] Wdata;
  logic signed [7:0] Rdata1, Rdata2;

  logic [7:0] rf [4] = '{default: 8'h00};
  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  logic [7:0] b2b_x  [3] = '{8'd40, 8'hF8, 8'd127};
  logic [7:0] b2b_y  [3] = '{8'd20, 8'd0, 8'd127};
  logic [7:0] b2b_x2 [3] = '{8'h3C, 8'd14, 8'hB2};
  logic [7:0] b2b_y2 [3] = '{8'hE7, 8'hF0, 8'd11};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) begin
      rf[Raddr1] <= Wdata;
      wr_cnt++;
    end
  end

  assign Rdata1 = rf[Raddr1];
  assign Rdata2 = rf[Raddr2];

  affine_seq dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .write    (write),
    .Raddr1   (Raddr1),
    .Raddr2   (Raddr2),
    .Wdata    (Wdata),
    .Rdata1   (Rdata1),
    .Rdata2   (Rdata2)
  );

  // Presents x then y on consecutive cycles; returns at the negedge after y is taken.
  task automatic drive_xy(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    in_data  = y;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    logic [15:0] obs;
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    obs = {in_ready, out_valid, busy, write, Raddr1, Raddr2, Wdata};
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 8'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 8100", obs);
    end
    n_reset = 1'b1;
    @(negedge clk);
    obs = {in_ready, out_valid, busy, write, Raddr1, Raddr2, Wdata};
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 8'd0}) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 8100", obs);
    end
  endtask

  task automatic test_transform(input string name, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] ex2, input logic [7:0] ey2);
    int lat;
    int wb;
    wb = wr_cnt;
    drive_xy(x, y);
    wait_done(lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL %s_latency: got %0d expected 3", name, lat); end
    checks++;
    if (rf[0] !== x) begin errors++; $display("FAIL %s_r0: got %h expected %h", name, rf[0], x); end
    checks++;
    if (rf[1] !== y) begin errors++; $display("FAIL %s_r1: got %h expected %h", name, rf[1], y); end
    checks++;
    if (rf[2] !== ex2) begin errors++; $display("FAIL %s_r2: got %h expected %h", name, rf[2], ex2); end
    checks++;
    if (rf[3] !== ey2) begin errors++; $display("FAIL %s_r3: got %h expected %h", name, rf[3], ey2); end
    checks++;
    if (wr_cnt - wb !== 4) begin errors++; $display("FAIL %s_writes: got %0d expected 4", name, wr_cnt - wb); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL %s_back_to_idle: got %b expected 100", name, {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_stall;
    int lat;
    logic [15:0] obs;
    drive_xy(8'd10, 8'd10);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'h55;
      @(negedge clk);
      obs = {out_valid, in_ready, busy, write, Raddr1, Raddr2, Wdata};
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 8'd0}) begin
        errors++;
        $display("FAIL stall_outputs_%0d: got %h expected a100", i, obs);
      end
      checks++;
      if ({rf[0], rf[1]} !== {8'd10, 8'd10}) begin
        errors++;
        $display("FAIL stall_r0r1_%0d: got %h expected 0a0a", i, {rf[0], rf[1]});
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
    checks++;
    if ({rf[2], rf[3]} !== {8'd32, 8'hEE}) begin
      errors++;
      $display("FAIL stall_r2r3: got %h expected 20ee", {rf[2], rf[3]});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL stall_release: got %b expected 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_abort;
    logic [15:0] obs;
    drive_xy(8'd100, 8'd100);
    @(negedge clk);
    checks++;
    if ({write, Raddr1} !== 3'b110) begin
      errors++;
      $display("FAIL abort_in_wr_x2: got %b expected 110", {write, Raddr1});
    end
    #1 n_reset = 1'b0;
    #1;
    obs = {in_ready, out_valid, busy, write, Raddr1, Raddr2, Wdata};
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 8'd0}) begin
      errors++;
      $display("FAIL abort_async_outputs: got %h expected 8100", obs);
    end
    @(negedge clk);
    n_reset = 1'b1;
    checks++;
    if (rf[2] !== 8'd32) begin
      errors++;
      $display("FAIL abort_r2_kept: got %h expected 20", rf[2]);
    end
    test_transform("abort_next", 8'd40, 8'd20, 8'h3C, 8'hE7);
  endtask

  task automatic test_gap;
    int lat;
    int wb;
    wb = wr_cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hF8;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, busy, write} !== 3'b110) begin
        errors++;
        $display("FAIL gap_hold_%0d: got %b expected 110", i, {in_ready, busy, write});
      end
    end
    in_valid = 1'b1;
    in_data  = 8'd0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL gap_latency: got %0d expected 3", lat); end
    checks++;
    if ({rf[2], rf[3]} !== {8'd14, 8'hF0}) begin
      errors++;
      $display("FAIL gap_r2r3: got %h expected 0ef0", {rf[2], rf[3]});
    end
    checks++;
    if (wr_cnt - wb !== 4) begin errors++; $display("FAIL gap_writes: got %0d expected 4", wr_cnt - wb); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int k;
    int t [3];
    k = 0;
    t = '{0, 0, 0};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && k < 3; c++) begin
      in_data = busy ? b2b_y[k] : b2b_x[k];
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if ({rf[2], rf[3]} !== {b2b_x2[k], b2b_y2[k]}) begin
          errors++;
          $display("FAIL b2b_job%0d_r2r3: got %h expected %h", k, {rf[2], rf[3]}, {b2b_x2[k], b2b_y2[k]});
        end
        t[k] = c;
        k++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    checks++;
    if (k !== 3) begin errors++; $display("FAIL b2b_jobs_done: got %0d expected 3", k); end
    checks++;
    if (t[1] - t[0] !== 6) begin errors++; $display("FAIL b2b_period_1: got %0d expected 6", t[1] - t[0]); end
    checks++;
    if (t[2] - t[1] !== 6) begin errors++; $display("FAIL b2b_period_2: got %0d expected 6", t[2] - t[1]); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_transform("basic", 8'd40, 8'd20, 8'h3C, 8'hE7);
    test_transform("neg_floor", 8'hF8, 8'd0, 8'd14, 8'hF0);
    test_transform("wrap", 8'd127, 8'd127, 8'hB2, 8'd11);
    test_stall();
    test_abort();
    test_gap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
